// File: rtl/mult_scheduler.sv
// Round-robin front end for an 8x8 shift-add multiplier: grants one requester at a time,
// sequences the multiplier through its 10-stage cycle and returns the product with its ID.

module multiplier (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  in1,
    input  logic [7:0]  in2,
    output logic [15:0] out
);
    logic [15:0] mcand_r;
    logic [15:0] acc_r;
    logic [7:0]  mplier_r;
    logic [3:0]  stage_r;

    // Stage 0 loads operands, stages 1..8 add-and-shift, stage 9 holds the product
    always_ff @(posedge clk) begin
        if (rst) begin
            mcand_r  <= 16'd0;
            acc_r    <= 16'd0;
            mplier_r <= 8'd0;
            stage_r  <= 4'd0;
        end else if (stage_r == 4'd0) begin
            mcand_r  <= {8'd0, in1};
            acc_r    <= 16'd0;
            mplier_r <= in2;
            stage_r  <= 4'd1;
        end else if (stage_r != 4'd9) begin
            if (mplier_r[0]) begin
                acc_r <= acc_r + mcand_r;
            end else begin
                acc_r <= acc_r;
            end
            mcand_r  <= mcand_r << 1;
            mplier_r <= mplier_r >> 1;
            stage_r  <= stage_r + 4'd1;
        end else begin
            stage_r <= stage_r;
        end
    end

    assign out = acc_r;
endmodule

module mult_scheduler #(
    parameter  int NREQ = 4,
    localparam int IDW  = $clog2(NREQ)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NREQ-1:0]     req_valid,
    input  logic [8*NREQ-1:0]   req_a,
    input  logic [8*NREQ-1:0]   req_b,
    output logic [NREQ-1:0]     req_ready,
    output logic                resp_valid,
    output logic [IDW-1:0]      resp_id,
    output logic [15:0]         resp_data,
    input  logic                resp_ready,
    output logic                busy
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_r;
    logic [IDW-1:0]  rr_ptr_r;
    logic [IDW-1:0]  res_id_r;
    logic [3:0]      cnt_r;
    logic [7:0]      op_a_r;
    logic [7:0]      op_b_r;
    logic [15:0]     res_r;
    logic [15:0]     mult_out_s;
    logic            mult_rst_s;
    logic            grant_any_s;
    logic [IDW-1:0]  grant_id_s;
    logic [NREQ-1:0] grant_s;

    function automatic logic [IDW-1:0] wrap_idx(input int v);
        return IDW'(v % NREQ);
    endfunction

    // First valid requester at or above rr_ptr, wrapping around
    always_comb begin
        grant_any_s = 1'b0;
        grant_id_s  = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!grant_any_s && req_valid[wrap_idx(int'(rr_ptr_r) + k)]) begin
                grant_any_s = 1'b1;
                grant_id_s  = wrap_idx(int'(rr_ptr_r) + k);
            end else begin
                grant_any_s = grant_any_s;
            end
        end
    end

    // Grant is only offered in IDLE and never while reset is asserted
    always_comb begin
        grant_s = '0;
        if ((state_r == IDLE) && !rst && grant_any_s) begin
            grant_s[grant_id_s] = 1'b1;
        end else begin
            grant_s = '0;
        end
    end

    assign req_ready  = grant_s;
    assign mult_rst_s = rst | (state_r != RUN);

    multiplier u_mult (
        .clk (clk),
        .rst (mult_rst_s),
        .in1 (op_a_r),
        .in2 (op_b_r),
        .out (mult_out_s)
    );

    // Scheduler FSM: accept, run the multiplier for 10 cycles, hold the response
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= IDLE;
            rr_ptr_r <= '0;
            cnt_r    <= 4'd0;
            op_a_r   <= 8'd0;
            op_b_r   <= 8'd0;
            res_r    <= 16'd0;
            res_id_r <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (grant_any_s) begin
                        op_a_r   <= req_a[{grant_id_s, 3'b000} +: 8];
                        op_b_r   <= req_b[{grant_id_s, 3'b000} +: 8];
                        res_id_r <= grant_id_s;
                        rr_ptr_r <= wrap_idx(int'(grant_id_s) + 1);
                        cnt_r    <= 4'd0;
                        state_r  <= RUN;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                RUN: begin
                    cnt_r <= cnt_r + 4'd1;
                    if (cnt_r == 4'd9) begin
                        res_r   <= mult_out_s;
                        state_r <= DONE;
                    end else begin
                        state_r <= RUN;
                    end
                end
                DONE: begin
                    if (resp_ready) begin
                        state_r <= IDLE;
                    end else begin
                        state_r <= DONE;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign resp_valid = (state_r == DONE);
    assign resp_data  = res_r;
    assign resp_id    = res_id_r;
    assign busy       = (state_r != IDLE);
endmodule

// File: tb/tb_mult_scheduler.sv
// Directed and random checks of mult_scheduler with a product scoreboard filled at grant
// and drained at response.

module tb_mult_scheduler;
    localparam int NREQ = 4;
    localparam int IDW  = 2;

    logic                clk = 1'b0;
    logic                rst;
    logic [NREQ-1:0]     req_valid;
    logic [8*NREQ-1:0]   req_a;
    logic [8*NREQ-1:0]   req_b;
    logic [NREQ-1:0]     req_ready;
    logic                resp_valid;
    logic [IDW-1:0]      resp_id;
    logic [15:0]         resp_data;
    logic                resp_ready;
    logic                busy;

    int checks = 0;
    int passes = 0;
    int cyc = 0;
    int grants_total = 0;
    int resp_total = 0;
    int sb_id[$];
    logic [15:0] sb_data[$];
    int wait_cnt[NREQ];
    int mon_gid;
    int e_id;
    logic [15:0] e_data;
    logic [7:0] mon_a;
    logic [7:0] mon_b;

    mult_scheduler #(.NREQ(NREQ)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_ready  (req_ready),
        .resp_valid (resp_valid),
        .resp_id    (resp_id),
        .resp_data  (resp_data),
        .resp_ready (resp_ready),
        .busy       (busy)
    );

    initial begin
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Scoreboard monitor: push on grant handshake, pop and compare on response handshake
    always @(negedge clk) begin
        if (rst) begin
            sb_id.delete();
            sb_data.delete();
            for (int i = 0; i < NREQ; i++) wait_cnt[i] = 0;
        end else begin
            check("ready_onehot0", 32'($onehot0(req_ready)), 32'd1);
            for (int i = 0; i < NREQ; i++) if (!req_valid[i]) wait_cnt[i] = 0;
            if ((req_valid & req_ready) != '0) begin
                mon_gid = 0;
                for (int i = 0; i < NREQ; i++) if (req_valid[i] && req_ready[i]) mon_gid = i;
                mon_a = req_a[8*mon_gid +: 8];
                mon_b = req_b[8*mon_gid +: 8];
                sb_id.push_back(mon_gid);
                sb_data.push_back(16'(mon_a) * 16'(mon_b));
                grants_total++;
                check("wait_bound", 32'(wait_cnt[mon_gid] <= NREQ - 1), 32'd1);
                wait_cnt[mon_gid] = 0;
                for (int i = 0; i < NREQ; i++) if (i != mon_gid && req_valid[i]) wait_cnt[i]++;
            end
            if (resp_valid && resp_ready) begin
                if (sb_id.size() == 0) begin
                    check("resp_unexpected", 32'd0, 32'd1);
                end else begin
                    e_id = sb_id.pop_front();
                    e_data = sb_data.pop_front();
                    check("resp_id", 32'(resp_id), 32'(e_id));
                    check("resp_data", 32'(resp_data), 32'(e_data));
                    resp_total++;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_grant(input int id);
        bit ok = 1'b0;
        for (int k = 0; k < 60; k++) begin
            if (req_ready[id]) begin ok = 1'b1; break; end
            step();
        end
        check("grant_timeout", 32'(ok), 32'd1);
    endtask

    task automatic wait_any(output int id);
        bit ok = 1'b0;
        id = -1;
        for (int k = 0; k < 60; k++) begin
            if (req_ready != '0) begin ok = 1'b1; break; end
            step();
        end
        for (int i = 0; i < NREQ; i++) if (req_ready[i]) id = i;
        check("grant_any_timeout", 32'(ok), 32'd1);
    endtask

    task automatic wait_resp();
        bit ok = 1'b0;
        for (int k = 0; k < 60; k++) begin
            if (resp_valid) begin ok = 1'b1; break; end
            step();
        end
        check("resp_timeout", 32'(ok), 32'd1);
    endtask

    task automatic drain();
        bit ok = 1'b0;
        resp_ready = 1'b1;
        for (int k = 0; k < 300; k++) begin
            if (!busy && sb_id.size() == 0) begin ok = 1'b1; break; end
            step();
        end
        check("drain_timeout", 32'(ok), 32'd1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req_valid = '1;
        step();
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_resp_id", 32'(resp_id), 32'd0);
        check("rst_resp_data", 32'(resp_data), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        req_valid = '0;
        step();
        rst = 1'b0;
        #1;
    endtask

    task automatic run_one(input int id, input logic [7:0] a, input logic [7:0] b,
                           input logic [15:0] exp);
        int e0;
        req_a[8*id +: 8] = a;
        req_b[8*id +: 8] = b;
        req_valid[id] = 1'b1;
        resp_ready = 1'b1;
        #1;
        wait_grant(id);
        e0 = cyc + 1;
        step();
        req_valid[id] = 1'b0;
        wait_resp();
        check("latency", 32'(cyc - e0), 32'd10);
        check("single_data", 32'(resp_data), 32'(exp));
        check("single_id", 32'(resp_id), 32'(id));
        step();
        check("busy_after", 32'(busy), 32'd0);
        check("valid_after", 32'(resp_valid), 32'd0);
    endtask

    initial begin
        int gid;
        int e0;
        int issued;
        int g_base;
        int r_base;
        bit soak_done;
        bit quiet;
        logic [NREQ-1:0] g;
        int rr_exp[5];

        rst = 1'b1;
        req_valid = '0;
        req_a = '0;
        req_b = '0;
        resp_ready = 1'b1;
        #1;
        do_reset();

        // single request and operand corners
        run_one(0, 8'd3, 8'd5, 16'h000F);
        run_one(0, 8'hFF, 8'hFF, 16'hFE01);
        run_one(2, 8'h00, 8'hA5, 16'h0000);
        run_one(3, 8'h80, 8'h01, 16'h0080);

        // round-robin with every requester pending from reset
        do_reset();
        rr_exp = '{0, 1, 2, 3, 0};
        for (int i = 0; i < NREQ; i++) begin
            req_a[8*i +: 8] = 8'(8'h10 + i);
            req_b[8*i +: 8] = 8'(8'h21 + 3 * i);
        end
        req_valid = '1;
        resp_ready = 1'b1;
        #1;
        for (int k = 0; k < 5; k++) begin
            wait_any(gid);
            check("rr_order", 32'(gid), 32'(rr_exp[k]));
            step();
            if (gid >= 0) req_a[8*gid +: 8] = req_a[8*gid +: 8] + 8'h40;
        end
        req_valid = '0;
        drain();

        // backpressure: response held, pending requester 1 not granted
        req_a[7:0] = 8'h12;
        req_b[7:0] = 8'h34;
        req_valid[0] = 1'b1;
        resp_ready = 1'b0;
        #1;
        wait_grant(0);
        step();
        req_valid[0] = 1'b0;
        req_a[15:8] = 8'h03;
        req_b[15:8] = 8'h03;
        req_valid[1] = 1'b1;
        wait_resp();
        for (int k = 0; k < 20; k++) begin
            check("bp_valid", 32'(resp_valid), 32'd1);
            check("bp_data", 32'(resp_data), 32'h03A8);
            check("bp_id", 32'(resp_id), 32'd0);
            check("bp_ready_held", 32'(req_ready), 32'd0);
            step();
        end
        resp_ready = 1'b1;
        #1;
        step();
        check("bp_grant_next", 32'(req_ready), 32'b0010);
        check("bp_valid_dropped", 32'(resp_valid), 32'd0);
        step();
        req_valid[1] = 1'b0;
        drain();

        // reset in the middle of a run discards the result
        req_a[15:8] = 8'd7;
        req_b[15:8] = 8'd9;
        req_valid[1] = 1'b1;
        #1;
        wait_grant(1);
        e0 = cyc + 1;
        step();
        req_valid[1] = 1'b0;
        while (cyc < e0 + 5) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        check("mid_rst_valid", 32'(resp_valid), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_ready", 32'(req_ready), 32'd0);
        quiet = 1'b1;
        for (int k = 0; k < 15; k++) begin
            if (resp_valid) quiet = 1'b0;
            step();
        end
        check("mid_rst_no_resp", 32'(quiet), 32'd1);
        req_a[23:16] = 8'd5;
        req_b[23:16] = 8'd5;
        req_valid[2] = 1'b1;
        req_a[7:0] = 8'd2;
        req_b[7:0] = 8'd4;
        req_valid[0] = 1'b1;
        #1;
        check("rr_ptr_after_rst", 32'(req_ready), 32'b0001);
        run_one(0, 8'd2, 8'd4, 16'h0008);
        wait_grant(2);
        step();
        req_valid[2] = 1'b0;
        drain();

        // random soak
        issued = 0;
        g = '0;
        g_base = grants_total;
        r_base = resp_total;
        soak_done = 1'b0;
        for (int c = 0; c < 60000; c++) begin
            step();
            req_valid = req_valid & ~g;
            for (int i = 0; i < NREQ; i++) begin
                if (!req_valid[i] && issued < 2000 && $urandom_range(0, 3) == 0) begin
                    req_a[8*i +: 8] = 8'($urandom_range(0, 255));
                    req_b[8*i +: 8] = 8'($urandom_range(0, 255));
                    req_valid[i] = 1'b1;
                    issued++;
                end
            end
            resp_ready = 1'($urandom_range(0, 1));
            #1;
            g = req_valid & req_ready;
            if (issued == 2000 && req_valid == '0 && !busy && sb_id.size() == 0) begin
                soak_done = 1'b1;
                break;
            end
        end
        check("soak_timeout", 32'(soak_done), 32'd1);
        check("soak_grants", 32'(grants_total - g_base), 32'd2000);
        check("soak_responses", 32'(resp_total - r_base), 32'd2000);
        check("soak_sb_empty", 32'(sb_id.size()), 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/mult_scheduler.md
# mult_scheduler

Arbitrating front end for the team's 8x8 shift-add `multiplier`, which it instantiates internally. Up to NREQ requesters submit operand pairs over valid/ready. A round-robin arbiter grants one request at a time. The block then sequences the multiplier through its 10-stage cycle by holding its reset and presenting stable operands. The 16-bit product is returned with the requester ID on a single backpressured response channel.

## Interface
- NREQ, 4, number of requesters; legal range 2..8.
- IDW, $clog2(NREQ), width of the requester ID; derived, never overridden.

- clk  in  1  single clock, rising edge.
- rst  in  1  reset, synchronous, active-high; clears all state, including the internal multiplier.
- req_valid  in  NREQ  bit i is requester i's request strobe.
- req_a  in  8*NREQ  requester i's multiplicand in bits [8i+7:8i]; drives multiplier in1.
- req_b  in  8*NREQ  requester i's multiplier in bits [8i+7:8i]; drives multiplier in2.
- req_ready  out  NREQ  one-hot or zero; bit i is high when requester i is granted this cycle.
- resp_valid  out  1  result available.
- resp_id  out  IDW  index of the requester that owns resp_data.
- resp_data  out  16  unsigned product req_a*req_b.
- resp_ready  in  1  consumer accepts the response.
- busy  out  1  high in RUN or DONE.

## Operation
- States are IDLE, RUN and DONE. Reset enters IDLE with rr_ptr=0, cnt=0, and op_a, op_b, res, res_id all 0.
- In IDLE:
  - The arbiter picks the first i with req_valid[i] set, scanning upward from rr_ptr and wrapping modulo NREQ.
  - req_ready[i] is driven combinationally high for the winner only. No other bit is high, and no bit is high outside IDLE.
  - On a handshake (req_valid[i] & req_ready[i]):
    - latch op_a=req_a[i], op_b=req_b[i] and res_id=i;
    - set rr_ptr=(i+1) mod NREQ;
    - clear cnt to 0;
    - go to RUN.
- Multiplier control:
  - mult_rst=1 in every cycle not in RUN, and also whenever rst=1.
  - Multiplier in1/in2 are driven from op_a/op_b only, never from the request bus, so they stay stable through RUN.
- In RUN, cnt increments every cycle. When cnt==9 (multiplier stage==9), capture res=multiplier out at that edge and go to DONE.
- In DONE:
  - resp_valid=1, with resp_data=res and resp_id=res_id held stable.
  - On resp_valid & resp_ready, go to IDLE.
  - Holding is unbounded while resp_ready=0.
- Arithmetic is unsigned 8x8→16; the maximum result is 0xFE01. No truncation is allowed.
- Requester-side rules:
  - A requester must hold req_valid and its operands until granted.
  - Dropping req_valid before grant is permitted; the arbiter simply skips that requester.
- rst in any state returns to IDLE immediately. An in-flight result is discarded; resp_valid=0 and req_ready=0 in the cycle after rst.

## Timing
- Reset values: req_ready=0 while rst is high, resp_valid=0, resp_id=0, resp_data=0, busy=0.
- Edge E0 is the accepting edge.
  - Cycle after E0: RUN, cnt=0, multiplier stage=0; the multiplier loads operands at E1.
  - Multiplier stage==9 in the 10th cycle after E0; res is captured at E10.
  - resp_valid is high from the cycle after E10.
  - Latency is 10 edges from accept to resp_valid.
- If resp_ready is already high when resp_valid rises, the response completes at E11 and IDLE is re-entered after E11.
  - A new grant can occur in that IDLE cycle.
  - Best-case throughput is one product per 12 cycles.
- Grant and response never overlap. A request pending during DONE waits for IDLE.
- Simultaneous requests: exactly one grant per IDLE cycle. Fairness: each requester waits at most NREQ-1 other products.
- rst asserted together with a handshake or with the response handshake: rst wins and nothing is latched or consumed.

## Test plan
- Single request: requester 0 sends a=3, b=5 with resp_ready=1 → resp_valid rises 10 edges after accept with resp_data=0x000F, resp_id=0, then busy drops.
- Maximum and zero operands: a=0xFF, b=0xFF → 0xFE01; a=0x00, b=0xA5 → 0x0000; a=0x80, b=0x01 → 0x0080.
- Round-robin: all four requesters valid from reset with distinct operands → grants in order 0,1,2,3,0. Each product and ID is correct, and req_ready is never multi-hot.
- Backpressure: resp_ready=0 for 20 cycles after resp_valid → resp_valid, resp_data and resp_id are held constant, requester 1's pending req_ready stays 0, and grant follows the first cycle with resp_ready=1.
- Reset mid-operation: rst pulsed at cnt==5 on an a=7, b=9 request → no response is produced and the state is IDLE. A subsequent request a=2, b=4 returns 0x0008 with normal latency, and rr_ptr is back at 0.
- Random soak: 2000 random requests with random resp_ready → every response equals the scoreboarded a*b for its ID, no request is lost or duplicated, and the wait bound of NREQ-1 is never exceeded.
